// File: rtl/cart_scan_streamer_if.sv
// Bundles the start/length control, the request/acknowledge memory port and the strobed byte stream.
// master is the streamer side; slave is the arbiter/detector/controller side.
interface cart_scan_streamer_if #(
    parameter int ADDR_W = 13,
    parameter int MEM_AW = 25
);
    logic              start;
    logic [MEM_AW-1:0] mem_base;
    logic [ADDR_W:0]   len;
    logic              mem_rd;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_enable;
    logic [7:0]        out_data;
    logic              busy;
    logic              done;

    modport master (
        input  start, mem_base, len, mem_ack, mem_data,
        output mem_rd, mem_addr, out_addr, out_enable, out_data, busy, done
    );

    modport slave (
        output start, mem_base, len, mem_ack, mem_data,
        input  mem_rd, mem_addr, out_addr, out_enable, out_data, busy, done
    );
endinterface

// File: rtl/cart_scan_streamer.sv
// Replays a stored cart image from stream address 0 as one strobed byte per memory fetch.
// Strobe follows the ack by one cycle (spacing 2+ack latency); mem_rd is held until acknowledged.
module cart_scan_streamer #(
    parameter int ADDR_W = 13,
    parameter int MEM_AW = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    cart_scan_streamer_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, EMIT, DONE} state_t;

    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_d;
    logic [MEM_AW-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W:0]   len_clamp;

    logic              mem_rd_q, mem_rd_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              out_enable_q, out_enable_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.out_enable = out_enable_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.out_data   = out_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            out_enable_q <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            base_q       <= base_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
            out_enable_q <= out_enable_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state;
        base_d       = base_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        mem_rd_d     = mem_rd_q;
        mem_addr_d   = mem_addr_q;
        out_enable_d = 1'b0;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        busy_d       = busy_q;
        done_d       = done_q;

        len_clamp = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
        cnt_inc   = cnt_q + CNT_ONE;

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    base_d = bus.mem_base;
                    len_d  = len_clamp;
                    cnt_d  = '0;
                    if (len_clamp == '0) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = REQ;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = bus.mem_base;
                    end
                end
            end
            REQ: begin
                // The ack is only honoured against an outstanding request.
                if (bus.mem_ack && mem_rd_q) begin
                    mem_rd_d     = 1'b0;
                    out_enable_d = 1'b1;
                    out_addr_d   = cnt_q[ADDR_W-1:0];
                    out_data_d   = bus.mem_data;
                    state_d      = EMIT;
                end
            end
            EMIT: begin
                cnt_d = cnt_inc;
                if (cnt_inc == len_q) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d    = REQ;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = base_q + MEM_AW'(cnt_inc);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    a_addr_stable: assert property (@(posedge clk) disable iff (reset)
        (mem_rd_q && !bus.mem_ack) |=> (mem_rd_q && $stable(mem_addr_q)));

    a_strobe_single: assert property (@(posedge clk) disable iff (reset)
        out_enable_q |=> !out_enable_q);

endmodule

// File: doc/cart_scan_streamer.md
Name: cart_scan_streamer

Overview:
- Replays a cart image already stored in external memory as a sequential byte stream (addr, enable, data) for the 2600 bankswitch/Superchip detectors.
- Fetches bytes over a request/acknowledge memory port and emits one strobed byte per fetch, always starting at stream address 0, which is the detectors' reset point.
- Sits between the SDRAM/ROM arbiter and the detector bank. Used when a cart is reloaded or rescanned without a fresh download.

Parameters:
- ADDR_W, 13, width of the stream address; the maximum stream length is 2^ADDR_W bytes.
- MEM_AW, 25, width of the memory-port byte address.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that begins a scan; ignored while busy=1
- mem_base  in  MEM_AW  memory address of image byte 0; latched on an accepted start
- len  in  ADDR_W+1  number of bytes to stream; latched on an accepted start
- mem_rd  out  1  read request, held high until acknowledged
- mem_addr  out  MEM_AW  read address, stable while mem_rd=1
- mem_ack  in  1  read acknowledge; mem_data is valid in the same cycle
- mem_data  in  8  read data
- out_addr  out  ADDR_W  stream address of the byte being emitted
- out_enable  out  1  one-cycle strobe marking a valid out_addr/out_data
- out_data  out  8  streamed byte
- busy  out  1  scan in progress
- done  out  1  level; high after a scan completes, until the next accepted start

Behaviour:
- Reset (async, any state): go to IDLE. mem_rd=0, mem_addr=0, out_enable=0, out_addr=0, out_data=0, busy=0, done=0. A scan interrupted by reset is abandoned and never resumed.
- States: IDLE, REQ, EMIT, DONE.
- IDLE/DONE with start=1:
  - Latch mem_base and len_eff = min(len, 2^ADDR_W). Clear done, set cnt=0.
  - If len_eff=0: go to DONE next cycle (done=1, busy=0) with no mem_rd and no out_enable.
  - Otherwise: go to REQ with busy=1.
- REQ:
  - mem_rd=1, mem_addr=base+cnt (zero-extended, modulo 2^MEM_AW).
  - On mem_ack=1 in a cycle where mem_rd=1: capture mem_data, drop mem_rd next cycle, go to EMIT. An ack arriving in the same cycle mem_rd first rises counts.
- EMIT (exactly one cycle):
  - out_enable=1, out_addr=cnt[ADDR_W-1:0], out_data=captured byte.
  - Then cnt=cnt+1. If the new cnt equals len_eff, go to DONE; otherwise go to REQ.
- DONE: busy=0, done=1. A start here begins a new scan (same rule as IDLE).
- Outputs are registered.
- Stream order and timing:
  - Addresses are strictly ascending 0..len_eff-1 with no gaps or repeats.
  - The first strobe always carries out_addr=0.
  - Minimum spacing between strobes is 2 cycles (ack latency 0). Spacing is 2+L for ack latency L.
- Timing from the start pulse (cycle 0):
  - mem_rd rises in cycle 1.
  - An ack in cycle a gives out_enable in cycle a+1.
  - After the final byte, done rises one cycle after its EMIT.
- Between strobes, out_addr/out_data hold their last values and out_enable=0.
- mem_ack while mem_rd=0 is ignored.
- start while busy=1 is ignored; the latched base and len are unchanged.
- len > 2^ADDR_W is clamped to 2^ADDR_W. Full length ends with out_addr=2^ADDR_W-1 and no wrap to 0.
- The counter is ADDR_W+1 bits so that cnt==len_eff is detectable at full length.

Test Plan:
- base=0x100, len=4, ack in the same cycle as mem_rd -> mem_addr 0x100..0x103. Strobes at cycles 2,4,6,8 with out_addr 0..3 and data matching memory. done=1 at cycle 9, busy low.
- len=3, ack latency 3 -> strobe spacing 5 cycles, mem_addr stable during each wait, exactly 3 strobes.
- len=0 -> done=1 at cycle 1. mem_rd and out_enable never asserted.
- len=0x3000, ADDR_W=13 -> exactly 8192 strobes, last out_addr=0x1FFF. A downstream detector fed this stream reports Superchip correctly for an image whose bytes 0x1000..0x107F repeat 0x0000..0x007F.
- Reset asserted after the 2nd strobe of a 6-byte scan -> all outputs 0 immediately. A new start replays from out_addr=0.
- start pulsed during busy with a different len -> ignored; the original len count of strobes completes. Spurious mem_ack while idle produces no strobe.
